// File: rtl/cache_params_pkg.sv
// Shared sizes, bus encodings and line helpers for the cache simulation environment.
// The backing memory and the cache both import this package.
package cache_params_pkg;

    localparam int BITS_IN_BYTE = 8;
    localparam int MEM_BYTES    = 1 << 19;
    localparam int LINE_BYTES   = 16;
    localparam int ADDR_W       = 15;
    localparam int DATA_W       = 16;
    localparam int MEM_LATENCY  = 100;
    localparam int LINE_W       = LINE_BYTES * BITS_IN_BYTE;
    localparam int BEATS        = LINE_W / DATA_W;
    localparam int LINES        = MEM_BYTES / LINE_BYTES;

    // CPU-side bus between the processor model and the cache
    typedef enum logic [2:0] {
        C1_NOP      = 3'd0,
        C1_READ8    = 3'd1,
        C1_READ16   = 3'd2,
        C1_READ32   = 3'd3,
        C1_WRITE8   = 3'd4,
        C1_WRITE16  = 3'd5,
        C1_WRITE32  = 3'd6,
        C1_RESPONSE = 3'd7
    } cmd1_e;

    // Memory-side bus between the cache and the backing memory
    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } cmd2_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE_CAPTURE,
        S_WAIT,
        S_RESPOND
    } mem_state_e;

    typedef logic [LINE_W-1:0] line_t;

    // Power-on contents: byte at address a is a[7:0] ^ a[15:8]. Only line-address
    // bits [11:0] reach those 16 byte-address bits, so that is all this takes.
    function automatic line_t init_line(input logic [11:0] line_lo);
        line_t l;
        l = '0;
        for (int b = 0; b < LINE_BYTES; b++) begin
            l[b*BITS_IN_BYTE +: BITS_IN_BYTE] = {line_lo[3:0], 4'(b)} ^ line_lo[11:4];
        end
        return l;
    endfunction

endpackage

// File: rtl/memory.sv
// Backing main memory: 512 KiB store of 16-byte lines served over a shared tri-state
// command/data bus with a fixed response latency after each line read or write.
module memory
    import cache_params_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              dump,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    inout  wire  [1:0]        cmd
);

    line_t             mem [LINES];
    mem_state_e        state;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        beat;
    logic [6:0]        lat_cnt;
    logic              is_write;
    logic [1:0]        cmd_q;
    logic [DATA_W-1:0] data_q;
    logic              cmd_oe;
    logic              data_oe;

    assign cmd  = cmd_oe  ? cmd_q  : 'z;
    assign data = data_oe ? data_q : 'z;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            beat     <= '0;
            lat_cnt  <= '0;
            is_write <= 1'b0;
            cmd_q    <= C2_NOP;
            data_q   <= '0;
            cmd_oe   <= 1'b0;
            data_oe  <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                mem[i] <= init_line(12'(i));
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd == C2_READ_LINE) begin
                        addr_q   <= addr;
                        is_write <= 1'b0;
                        lat_cnt  <= '0;
                        state    <= S_WAIT;
                    end else if (cmd == C2_WRITE_LINE) begin
                        addr_q            <= addr;
                        is_write          <= 1'b1;
                        mem[addr][DATA_W-1:0] <= data;
                        beat              <= 4'd1;
                        state             <= S_WRITE_CAPTURE;
                    end
                end

                // Beats 1..7 follow on consecutive edges; the master's cmd is irrelevant here
                S_WRITE_CAPTURE: begin
                    mem[addr_q][{beat[2:0], 4'b0000} +: DATA_W] <= data;
                    if (beat == 4'(BEATS - 1)) begin
                        beat    <= '0;
                        lat_cnt <= '0;
                        state   <= S_WAIT;
                    end else begin
                        beat <= beat + 4'd1;
                    end
                end

                // Leaving on the MEM_LATENCY-th edge makes beat 0 visible right after it
                S_WAIT: begin
                    if (lat_cnt == 7'(MEM_LATENCY - 1)) begin
                        lat_cnt <= '0;
                        cmd_oe  <= 1'b1;
                        cmd_q   <= C2_RESPONSE;
                        if (!is_write) begin
                            data_oe <= 1'b1;
                            data_q  <= mem[addr_q][DATA_W-1:0];
                        end
                        beat  <= 4'd1;
                        state <= S_RESPOND;
                    end else begin
                        lat_cnt <= lat_cnt + 7'd1;
                    end
                end

                S_RESPOND: begin
                    if (is_write || beat == 4'(BEATS)) begin
                        cmd_oe  <= 1'b0;
                        data_oe <= 1'b0;
                        cmd_q   <= C2_NOP;
                        beat    <= '0;
                        state   <= S_IDLE;
                    end else begin
                        data_q <= mem[addr_q][{beat[2:0], 4'b0000} +: DATA_W];
                        beat   <= beat + 4'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end

        // Contents shown are those before this edge's update
        if (dump) begin
            for (int i = 0; i < LINES; i++) begin
                $display("%04h: %032h", 15'(i), mem[i]);
            end
        end
    end

endmodule

// File: tb/tb_memory.sv
// Directed bench for the backing memory: table of line reads plus hand-written
// write, overlap, reset-abort and dump sequences.
module tb_memory;
    import cache_params_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              dump;
    logic [ADDR_W-1:0] addr;
    wire  [DATA_W-1:0] data;
    wire  [1:0]        cmd;

    logic              m_cmd_oe;
    logic              m_data_oe;
    logic [1:0]        m_cmd;
    logic [DATA_W-1:0] m_data;

    assign cmd  = m_cmd_oe  ? m_cmd  : 'z;
    assign data = m_data_oe ? m_data : 'z;

    always #5 clk = ~clk;

    memory dut (
        .clk   (clk),
        .reset (reset),
        .dump  (dump),
        .addr  (addr),
        .data  (data),
        .cmd   (cmd)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [127:0]      exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_bus();
        m_cmd_oe  = 1'b0;
        m_data_oe = 1'b0;
    endtask

    // Drive zeros on the selected buses; reading back zero means the memory is not driving.
    task automatic probe(input string name, input bit on_cmd, input bit on_data);
        logic [127:0] act;
        m_cmd     = 2'd0;
        m_data    = '0;
        m_cmd_oe  = on_cmd;
        m_data_oe = on_data;
        #1;
        act = '0;
        if (on_cmd)  act[1:0]   = cmd;
        if (on_data) act[31:16] = data;
        check(name, act, '0);
        release_bus();
    endtask

    task automatic read_line(input logic [ADDR_W-1:0] a, input bit with_dump, input string nm,
                             output logic [127:0] got);
        bit resp_ok;
        m_cmd    = C2_READ_LINE;
        m_cmd_oe = 1'b1;
        addr     = a;
        dump     = with_dump;
        tick();
        release_bus();
        dump = 1'b0;
        repeat (MEM_LATENCY - 1) tick();
        probe({nm, " early"}, 1'b1, 1'b0);
        resp_ok = 1'b1;
        got     = '0;
        for (int k = 0; k < BEATS; k++) begin
            tick();
            if (cmd !== C2_RESPONSE) resp_ok = 1'b0;
            got[k*16 +: 16] = data;
        end
        check({nm, " resp_cmd"}, 128'(resp_ok), 128'd1);
        tick();
        probe({nm, " release"}, 1'b1, 1'b1);
    endtask

    task automatic write_line(input logic [ADDR_W-1:0] a, input logic [127:0] line, input string nm);
        m_cmd     = C2_WRITE_LINE;
        m_cmd_oe  = 1'b1;
        addr      = a;
        m_data    = line[15:0];
        m_data_oe = 1'b1;
        tick();
        m_cmd = C2_NOP;
        for (int k = 1; k < BEATS; k++) begin
            m_data = line[k*16 +: 16];
            tick();
        end
        release_bus();
        repeat (MEM_LATENCY - 1) tick();
        probe({nm, " early"}, 1'b1, 1'b0);
        tick();
        check({nm, " resp_cmd"}, 128'(cmd), 128'(C2_RESPONSE));
        probe({nm, " resp_data_z"}, 1'b0, 1'b1);
        tick();
        probe({nm, " release"}, 1'b1, 1'b1);
    endtask

    initial begin
        logic [127:0] got;
        logic [127:0] wline;
        int           n_resp;
        int           first_resp;

        vecs[0] = '{a: 15'h0000, exp: 128'h0F0E0D0C0B0A09080706050403020100};
        vecs[1] = '{a: 15'h7FFF, exp: 128'h000102030405060708090A0B0C0D0E0F};
        vecs[2] = '{a: 15'h00FF, exp: 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF};
        vecs[3] = '{a: 15'h1233, exp: 128'h1C1D1E1F18191A1B1415161710111213};
        vecs[4] = '{a: 15'h1234, exp: 128'h6C6D6E6F68696A6B6465666760616263};
        wline   = 128'hA007A006A005A004A003A002A001A000;

        reset  = 1'b1;
        dump   = 1'b0;
        addr   = '0;
        m_cmd  = C2_NOP;
        m_data = '0;
        release_bus();
        repeat (3) tick();
        reset = 1'b0;
        probe("reset_bus_z", 1'b1, 1'b1);

        for (int i = 0; i < 5; i++) begin
            read_line(vecs[i].a, 1'b0, $sformatf("read%0d", i), got);
            check($sformatf("read%0d_data", i), got, vecs[i].exp);
        end

        write_line(15'h1234, wline, "write1234");
        read_line(15'h1234, 1'b1, "rd_after_wr", got);
        check("rd_after_wr_data", got, wline);
        read_line(15'h1233, 1'b0, "neighbour", got);
        check("neighbour_data", got, vecs[3].exp);

        // Second READ_LINE during WAIT must be dropped
        m_cmd    = C2_READ_LINE;
        m_cmd_oe = 1'b1;
        addr     = 15'h0000;
        tick();
        release_bus();
        n_resp     = 0;
        first_resp = -1;
        got        = '0;
        for (int c = 1; c <= 260; c++) begin
            if (c == 50) begin
                m_cmd    = C2_READ_LINE;
                m_cmd_oe = 1'b1;
                addr     = 15'h7FFF;
            end else if (c == 51) begin
                release_bus();
            end
            tick();
            if (cmd === C2_RESPONSE) begin
                if (first_resp < 0) first_resp = c;
                if (n_resp < BEATS) got[n_resp*16 +: 16] = data;
                n_resp++;
            end
        end
        check("overlap_beats", 128'(n_resp), 128'd8);
        check("overlap_first", 128'(first_resp), 128'(MEM_LATENCY));
        check("overlap_data", got, vecs[0].exp);

        // Reset 50 cycles into a read of the written line
        m_cmd    = C2_READ_LINE;
        m_cmd_oe = 1'b1;
        addr     = 15'h1234;
        tick();
        release_bus();
        repeat (49) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        probe("abort_bus_z", 1'b1, 1'b1);
        n_resp = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (cmd === C2_RESPONSE) n_resp++;
        end
        check("abort_no_resp", 128'(n_resp), 128'd0);
        read_line(15'h1234, 1'b0, "after_abort", got);
        check("after_abort_data", got, vecs[4].exp);

        // Reset in the middle of a write restores the initial contents
        m_cmd     = C2_WRITE_LINE;
        m_cmd_oe  = 1'b1;
        addr      = 15'h0000;
        m_data    = 16'hDEAD;
        m_data_oe = 1'b1;
        tick();
        m_cmd  = C2_NOP;
        m_data = 16'hBEEF;
        tick();
        m_data = 16'hCAFE;
        tick();
        release_bus();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        probe("midwrite_bus_z", 1'b1, 1'b1);
        read_line(15'h0000, 1'b0, "after_midwrite", got);
        check("after_midwrite_data", got, vecs[0].exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
